// File: rtl/spi_cfg_pkg.sv
// spi_cfg_pkg: shared constants and helpers for the SPI coefficient register file.
//   - SPI frame layout (32 bits, MSB first: R/W, 7-bit address, 24-bit data)
//   - default commit and status addresses
//   - addr_to_bank_quad(): maps a register address onto {valid, bank, quad}
package spi_cfg_pkg;

  localparam int FRAME_LEN = 32;
  localparam int RW_BIT    = 31;
  localparam int ADDR_MSB  = 30;
  localparam int ADDR_LSB  = 24;
  localparam int DATA_MSB  = 23;

  localparam logic [6:0] ADDR_COMMIT_DEF = 7'h7E;
  localparam logic [6:0] ADDR_STATUS_DEF = 7'h7F;

  typedef struct packed {
    logic       valid;
    logic [6:0] bank;
    logic [6:0] quad;
  } bank_quad_t;

  // Address 1 + b*(taps/4) + q holds taps 4q..4q+3 of bank b; address 0
  // and anything past the last bank decode as invalid.
  function automatic bank_quad_t addr_to_bank_quad(input logic [6:0] addr,
                                                   input int taps,
                                                   input int banks);
    bank_quad_t r;
    int qpb;
    int idx;
    qpb = taps / 4;
    r   = '0;
    if (addr >= 7'd1 && int'(addr) <= banks * qpb) begin
      idx     = int'(addr) - 1;
      r.valid = 1'b1;
      r.bank  = 7'(idx / qpb);
      r.quad  = 7'(idx % qpb);
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_coef_regfile_if.sv
// spi_coef_regfile_if: SPI pin bundle (mode 0 slave side).
//   spi_sclk, spi_ss (active low), spi_mosi : master -> slave
//   spi_miso, spi_miso_oe                   : slave -> master
interface spi_coef_regfile_if;
  logic spi_sclk;
  logic spi_ss;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport slave  (input spi_sclk, spi_ss, spi_mosi, output spi_miso, spi_miso_oe);
  modport master (output spi_sclk, spi_ss, spi_mosi, input spi_miso, spi_miso_oe);
endinterface

// File: rtl/spi_frame_rx.sv
// spi_frame_rx: oversampled SPI mode-0 frame receiver/transmitter.
//   clock, reset       : system clock, synchronous active-high reset
//   sclk_i/ss_n_i/mosi_i : raw SPI pins (asynchronous)
//   rd_word_i          : read data, sampled when addr_valid_o is high
//   miso_o, miso_oe_o  : serial output and its enable
//   addr_valid_o, hdr_addr_o : strobe after the 8th bit with the address
//   frame_done_o + frame_rw_o/frame_addr_o/frame_data_o : strobe on bit 32
//   frame_abort_o      : slave select released after 1..31 bits
module spi_frame_rx
  import spi_cfg_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        sclk_i,
  input  logic        ss_n_i,
  input  logic        mosi_i,
  input  logic [23:0] rd_word_i,
  output logic        miso_o,
  output logic        miso_oe_o,
  output logic        addr_valid_o,
  output logic [6:0]  hdr_addr_o,
  output logic        frame_done_o,
  output logic        frame_rw_o,
  output logic [6:0]  frame_addr_o,
  output logic [23:0] frame_data_o,
  output logic        frame_abort_o
);

  logic [1:0]           sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic                 sclk_prev_q, ss_prev_q, armed_q;
  logic [5:0]           bit_cnt_q;
  logic [FRAME_LEN-2:0] rx_sr_q;
  logic [23:0]          miso_sr_q;
  logic                 miso_q, miso_oe_q;

  logic                 sclk_s, ss_s, mosi_s;
  logic                 sclk_rise, sclk_fall, ss_rise, active, bit_strobe;
  logic [FRAME_LEN-1:0] rx_d;

  assign sclk_s    = sclk_sync_q[1];
  assign ss_s      = ss_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ss_rise   = ss_s & ~ss_prev_q;

  // After reset the receiver stays disarmed until slave select has been
  // seen high, so a frame cut by reset is never picked up half-way.
  assign active     = armed_q & ~ss_s;
  // Bits past the 32nd are ignored: the counter stops at FRAME_LEN.
  assign bit_strobe = active && sclk_rise && (bit_cnt_q < 6'(FRAME_LEN));
  assign rx_d       = {rx_sr_q, mosi_s};

  assign addr_valid_o  = bit_strobe && (bit_cnt_q == 6'd7);
  assign hdr_addr_o    = rx_d[6:0];
  assign frame_done_o  = bit_strobe && (bit_cnt_q == 6'(FRAME_LEN - 1));
  assign frame_rw_o    = rx_d[RW_BIT];
  assign frame_addr_o  = rx_d[ADDR_MSB:ADDR_LSB];
  assign frame_data_o  = rx_d[DATA_MSB:0];
  assign frame_abort_o = armed_q && ss_rise && (bit_cnt_q != 6'd0) &&
                         (bit_cnt_q < 6'(FRAME_LEN));

  assign miso_o    = miso_q;
  assign miso_oe_o = miso_oe_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b0;
      armed_q     <= 1'b0;
      bit_cnt_q   <= '0;
      rx_sr_q     <= '0;
      miso_sr_q   <= '0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], sclk_i};
      ss_sync_q   <= {ss_sync_q[0], ss_n_i};
      mosi_sync_q <= {mosi_sync_q[0], mosi_i};
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
      miso_oe_q   <= active;
      if (ss_s) begin
        armed_q <= 1'b1;
      end
      if (!active) begin
        bit_cnt_q <= '0;
        miso_q    <= 1'b0;
      end else begin
        if (bit_strobe) begin
          bit_cnt_q <= bit_cnt_q + 6'd1;
          rx_sr_q   <= rx_d[FRAME_LEN-2:0];
        end
        if (addr_valid_o) begin
          miso_sr_q <= rd_word_i;
        end
        // Header bits go out as 0; data leaves MSB first from the falling
        // edge that ends bit 7, so the master samples it on rise 9.
        if (sclk_fall && bit_cnt_q >= 6'd8) begin
          miso_q    <= miso_sr_q[23];
          miso_sr_q <= {miso_sr_q[22:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/spi_coef_regfile.sv
// spi_coef_regfile: double-buffered coefficient register file behind SPI.
//   clock, reset : system clock, synchronous active-high reset
//   spi          : SPI slave pins (spi_coef_regfile_if.slave)
//   coef         : active coefficients, bank b tap t at
//                  [((b*TAPS+t)+1)*COEF_W-1 -: COEF_W]
//   coef_update  : one-cycle pulse when the active set is committed
//   frame_err    : one-cycle pulse per aborted frame or bad write
module spi_coef_regfile
  import spi_cfg_pkg::*;
#(
  parameter int         COEF_W      = 5,
  parameter int         TAPS        = 8,
  parameter int         BANKS       = 4,
  parameter logic [6:0] ADDR_COMMIT = ADDR_COMMIT_DEF,
  parameter logic [6:0] ADDR_STATUS = ADDR_STATUS_DEF
)
(
  input  logic                          clock,
  input  logic                          reset,
  spi_coef_regfile_if.slave             spi,
  output logic [BANKS*TAPS*COEF_W-1:0]  coef,
  output logic                          coef_update,
  output logic                          frame_err
);

  localparam int QPB = TAPS / 4;
  localparam int NW  = BANKS * QPB;
  localparam int WW  = 4 * COEF_W;

  logic [WW-1:0] shadow_q [NW];
  logic [WW-1:0] active_q [NW];
  logic [7:0]    err_cnt_q;
  logic          coef_update_q, frame_err_q;

  logic          addr_valid, frame_done, frame_rw, frame_abort;
  logic [6:0]    hdr_addr, frame_addr, rd_idx, wr_idx;
  logic [23:0]   frame_data, rd_word;
  bank_quad_t    rd_bq, wr_bq;
  logic          wr_go, commit_go, err_go, busy;
  logic          unused_data;

  spi_frame_rx u_rx (
    .clock        (clock),
    .reset        (reset),
    .sclk_i       (spi.spi_sclk),
    .ss_n_i       (spi.spi_ss),
    .mosi_i       (spi.spi_mosi),
    .rd_word_i    (rd_word),
    .miso_o       (spi.spi_miso),
    .miso_oe_o    (spi.spi_miso_oe),
    .addr_valid_o (addr_valid),
    .hdr_addr_o   (hdr_addr),
    .frame_done_o (frame_done),
    .frame_rw_o   (frame_rw),
    .frame_addr_o (frame_addr),
    .frame_data_o (frame_data),
    .frame_abort_o(frame_abort)
  );

  assign rd_bq  = addr_to_bank_quad(hdr_addr, TAPS, BANKS);
  assign rd_idx = rd_bq.bank * 7'(QPB) + rd_bq.quad;
  assign wr_bq  = addr_to_bank_quad(frame_addr, TAPS, BANKS);
  assign wr_idx = wr_bq.bank * 7'(QPB) + wr_bq.quad;

  // Low data bits below the four packed words are don't-care on write.
  assign unused_data = ^frame_data;

  assign wr_go     = frame_done && frame_rw && wr_bq.valid;
  assign commit_go = frame_done && frame_rw && (frame_addr == ADDR_COMMIT) &&
                     frame_data[0];
  // Any write that is neither mapped nor the commit register is an error;
  // reads of unmapped addresses are legal and return 0.
  assign err_go    = frame_abort ||
                     (frame_done && frame_rw && !wr_bq.valid &&
                      (frame_addr != ADDR_COMMIT));
  assign busy      = commit_go;

  always_comb begin
    rd_word = '0;
    if (rd_bq.valid) begin
      for (int i = 0; i < NW; i++) begin
        if (rd_idx == 7'(i)) begin
          rd_word[23 -: WW] = shadow_q[i];
        end
      end
    end else if (hdr_addr == ADDR_STATUS) begin
      rd_word = {err_cnt_q, 15'b0, busy};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NW; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      err_cnt_q     <= '0;
      coef_update_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      coef_update_q <= commit_go;
      frame_err_q   <= err_go;
      if (err_go && err_cnt_q != 8'hFF) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
      for (int i = 0; i < NW; i++) begin
        if (commit_go) begin
          active_q[i] <= shadow_q[i];
        end
        if (wr_go && wr_idx == 7'(i)) begin
          shadow_q[i] <= frame_data[23 -: WW];
        end
      end
    end
  end

  for (genvar gi = 0; gi < NW; gi++) begin : g_word
    for (genvar gk = 0; gk < 4; gk++) begin : g_tap
      assign coef[(gi*4+gk+1)*COEF_W-1 -: COEF_W] =
        active_q[gi][WW-1-gk*COEF_W -: COEF_W];
    end
  end

  assign coef_update = coef_update_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_coef_regfile.sv
// tb_spi_coef_regfile: scenario tasks driving SPI frames into spi_coef_regfile,
// with a read scoreboard and a small register model for expected values.
module tb_spi_coef_regfile;
  import spi_cfg_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [159:0] coef;
  logic coef_update, frame_err;

  spi_coef_regfile_if spi();

  spi_coef_regfile #(.COEF_W(5), .TAPS(8), .BANKS(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .spi        (spi),
    .coef       (coef),
    .coef_update(coef_update),
    .frame_err  (frame_err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int upd_cnt = 0;
  int err_pulses = 0;

  always @(posedge clock) begin
    if (coef_update) upd_cnt <= upd_cnt + 1;
    if (frame_err) err_pulses <= err_pulses + 1;
  end

  logic [23:0] m_shadow [8];
  logic [23:0] m_active [8];
  int          m_err;
  logic [23:0] exp_q [$];
  logic [31:0] rx_word;
  logic        oe_seen;
  logic [23:0] e;

  function automatic logic [159:0] exp_coef();
    logic [159:0] r;
    r = '0;
    for (int w = 0; w < 8; w++)
      for (int k = 0; k < 4; k++)
        r[(w*4+k+1)*5-1 -: 5] = m_active[w][23-5*k -: 5];
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_err = 0;
  endtask

  // One SPI frame; all delays are multiples of 10 so edges land on clock negedges.
  task automatic spi_xfer(input logic [31:0] word, input int nbits, input int rst_at);
    spi.spi_ss = 1'b0;
    rx_word = '0;
    oe_seen = 1'b0;
    #40;
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        reset = 1'b1;
        #20 reset = 1'b0;
        model_clear();
        #20;
      end
      spi.spi_mosi = (i < 32) ? word[31-i] : 1'b1;
      #40 spi.spi_sclk = 1'b1;
      if (i < 32) rx_word = {rx_word[30:0], spi.spi_miso};
      if (i == 16) oe_seen = spi.spi_miso_oe;
      #40 spi.spi_sclk = 1'b0;
    end
    #40 spi.spi_ss = 1'b1;
    #120;
  endtask

  task automatic do_write(input logic [6:0] addr, input logic [23:0] data);
    spi_xfer({1'b1, addr, data}, 32, -1);
    $display("write addr=%h data=%h", addr, data);
    if (addr >= 7'd1 && addr <= 7'd8) m_shadow[addr-1] = data & 24'hFFFFF0;
    else if (addr == 7'h7E) begin
      if (data[0]) m_active = m_shadow;
    end else m_err++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #20 reset = 1'b0;
    model_clear();
    #100;
    total++;
    if (coef !== 160'h0) begin bad++; $display("FAIL reset_coef: got=%h want=0", coef); end
    total++;
    if (spi.spi_miso_oe !== 1'b0) begin bad++; $display("FAIL reset_oe: got=%b want=0", spi.spi_miso_oe); end
    total++;
    if ({coef_update, frame_err, spi.spi_miso} !== 3'b000) begin
      bad++; $display("FAIL reset_pulses: got=%b want=000", {coef_update, frame_err, spi.spi_miso});
    end
    exp_q.push_back({8'd0, 15'd0, 1'b0});
    spi_xfer({1'b0, 7'h7F, 24'h0}, 32, -1);
    e = exp_q.pop_front();
    total++;
    if (rx_word !== {8'h00, e}) begin bad++; $display("FAIL reset_status: got=%h want=%h", rx_word, {8'h00, e}); end
    $display("reset: status read %h", rx_word);
  endtask

  task automatic test_write_commit();
    int u0;
    u0 = upd_cnt;
    do_write(7'h03, 24'h088640);
    total++;
    if (coef !== 160'h0) begin bad++; $display("FAIL shadow_isolated: got=%h want=0", coef); end
    do_write(7'h7E, 24'h000000);
    total++;
    if (upd_cnt !== u0) begin bad++; $display("FAIL noop_commit: got=%0d want=%0d", upd_cnt, u0); end
    do_write(7'h7E, 24'h000001);
    total++;
    if (upd_cnt !== u0 + 1) begin bad++; $display("FAIL commit_pulse: got=%0d want=%0d", upd_cnt, u0 + 1); end
    total++;
    if (coef !== exp_coef()) begin bad++; $display("FAIL commit_coef: got=%h want=%h", coef, exp_coef()); end
    for (int t = 0; t < 4; t++) begin
      total++;
      if (coef[(9+t)*5-1 -: 5] !== 5'(t + 1)) begin
        bad++; $display("FAIL bank1_tap%0d: got=%0d want=%0d", t, coef[(9+t)*5-1 -: 5], t + 1);
      end
    end
  endtask

  task automatic test_readback();
    exp_q.push_back(24'h088640);
    spi_xfer({1'b0, 7'h03, 24'h0}, 32, -1);
    e = exp_q.pop_front();
    total++;
    if (rx_word !== {8'h00, e}) begin bad++; $display("FAIL readback: got=%h want=%h", rx_word, {8'h00, e}); end
    total++;
    if (oe_seen !== 1'b1) begin bad++; $display("FAIL miso_oe_frame: got=%b want=1", oe_seen); end
    $display("read addr=03 got=%h", rx_word);
  endtask

  task automatic test_abort();
    int e0;
    e0 = err_pulses;
    spi_xfer({1'b1, 7'h01, 24'hFFFFF0}, 20, -1);
    m_err++;
    $display("abort after 20 bits");
    total++;
    if (err_pulses !== e0 + 1) begin bad++; $display("FAIL abort_err_pulse: got=%0d want=%0d", err_pulses, e0 + 1); end
    exp_q.push_back(m_shadow[0]);
    spi_xfer({1'b0, 7'h01, 24'h0}, 32, -1);
    e = exp_q.pop_front();
    total++;
    if (rx_word !== {8'h00, e}) begin bad++; $display("FAIL abort_shadow: got=%h want=%h", rx_word, {8'h00, e}); end
    exp_q.push_back({8'(m_err), 15'd0, 1'b0});
    spi_xfer({1'b0, 7'h7F, 24'h0}, 32, -1);
    e = exp_q.pop_front();
    total++;
    if (rx_word !== {8'h00, e}) begin bad++; $display("FAIL abort_errcnt: got=%h want=%h", rx_word, {8'h00, e}); end
  endtask

  task automatic test_unmapped();
    int e0;
    e0 = err_pulses;
    do_write(7'h40, 24'hABCDE0);
    do_write(7'h7F, 24'h123456);
    total++;
    if (err_pulses !== e0 + 2) begin bad++; $display("FAIL unmapped_err_pulse: got=%0d want=%0d", err_pulses, e0 + 2); end
    exp_q.push_back(24'h0);
    spi_xfer({1'b0, 7'h40, 24'h0}, 32, -1);
    e = exp_q.pop_front();
    total++;
    if (rx_word !== {8'h00, e}) begin bad++; $display("FAIL unmapped_read: got=%h want=%h", rx_word, {8'h00, e}); end
    exp_q.push_back({8'(m_err), 15'd0, 1'b0});
    spi_xfer({1'b0, 7'h7F, 24'h0}, 32, -1);
    e = exp_q.pop_front();
    total++;
    if (rx_word !== {8'h00, e}) begin bad++; $display("FAIL unmapped_errcnt: got=%h want=%h", rx_word, {8'h00, e}); end
    total++;
    if (coef !== exp_coef()) begin bad++; $display("FAIL unmapped_coef: got=%h want=%h", coef, exp_coef()); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] d;
    int e0;
    e0 = err_pulses;
    for (int a = 1; a <= 8; a++) begin
      d = 24'($urandom);
      do_write(7'(a), d);
    end
    do_write(7'h7E, 24'h000001);
    total++;
    if (coef !== exp_coef()) begin bad++; $display("FAIL b2b_coef: got=%h want=%h", coef, exp_coef()); end
    total++;
    if (err_pulses !== e0) begin bad++; $display("FAIL b2b_no_err: got=%0d want=%0d", err_pulses, e0); end
    for (int a = 1; a <= 8; a += 7) begin
      exp_q.push_back(m_shadow[a-1]);
      spi_xfer({1'b0, 7'(a), 24'h0}, 32, -1);
      e = exp_q.pop_front();
      total++;
      if (rx_word !== {8'h00, e}) begin bad++; $display("FAIL b2b_read%0d: got=%h want=%h", a, rx_word, {8'h00, e}); end
      $display("read addr=%0d got=%h", a, rx_word);
    end
  endtask

  task automatic test_overlong_reset();
    int e0;
    e0 = err_pulses;
    spi_xfer({1'b1, 7'h01, 24'h5A5A50}, 40, -1);
    m_shadow[0] = 24'h5A5A50;
    $display("overlong write addr=01 data=5a5a50");
    total++;
    if (err_pulses !== e0) begin bad++; $display("FAIL overlong_no_err: got=%0d want=%0d", err_pulses, e0); end
    exp_q.push_back(m_shadow[0]);
    spi_xfer({1'b0, 7'h01, 24'h0}, 32, -1);
    e = exp_q.pop_front();
    total++;
    if (rx_word !== {8'h00, e}) begin bad++; $display("FAIL overlong_read: got=%h want=%h", rx_word, {8'h00, e}); end
    e0 = err_pulses;
    spi_xfer({1'b1, 7'h02, 24'h123450}, 32, 16);
    $display("reset at bit 16 of write addr=02");
    total++;
    if (err_pulses !== e0) begin bad++; $display("FAIL midreset_no_err: got=%0d want=%0d", err_pulses, e0); end
    total++;
    if (coef !== 160'h0) begin bad++; $display("FAIL midreset_coef: got=%h want=0", coef); end
    exp_q.push_back(24'h0);
    spi_xfer({1'b0, 7'h02, 24'h0}, 32, -1);
    e = exp_q.pop_front();
    total++;
    if (rx_word !== {8'h00, e}) begin bad++; $display("FAIL midreset_shadow: got=%h want=%h", rx_word, {8'h00, e}); end
    do_write(7'h04, 24'h0F0F00);
    do_write(7'h7E, 24'h000001);
    total++;
    if (coef !== exp_coef()) begin bad++; $display("FAIL post_reset_coef: got=%h want=%h", coef, exp_coef()); end
    exp_q.push_back(24'h0F0F00);
    spi_xfer({1'b0, 7'h04, 24'h0}, 32, -1);
    e = exp_q.pop_front();
    total++;
    if (rx_word !== {8'h00, e}) begin bad++; $display("FAIL post_reset_read: got=%h want=%h", rx_word, {8'h00, e}); end
  endtask

  initial begin
    spi.spi_ss   = 1'b1;
    spi.spi_sclk = 1'b0;
    spi.spi_mosi = 1'b0;
    model_clear();
    #40;
    test_reset();
    test_write_commit();
    test_readback();
    test_abort();
    test_unmapped();
    test_back_to_back();
    test_overlong_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_coef_regfile.md
# spi_coef_regfile

Parametrised SPI-slave coefficient register file for the delta-sigma modulator's weight banks, the successor to the fixed 4×8×5-bit SPI loader. It runs entirely on the system clock, oversampling the SPI pins. It supports write and read-back frames and double-buffers coefficients so the datapath only sees complete, atomically committed weight sets. It also counts malformed frames.

## Interface
- COEF_W, 5: coefficient width in bits; requires 4*COEF_W <= 24.
- TAPS, 8: coefficients per bank; must be a multiple of 4.
- BANKS, 4: number of weight banks (cos1, sin1, cos2, sin2, …).
- ADDR_COMMIT, 7'h7E: write-only commit address.
- ADDR_STATUS, 7'h7F: read-only status address.
- clock  in  1  system clock; the block's only clock. It must be at least 4× the SPI SCLK rate.
- reset  in  1  synchronous, active-high reset.
- spi_sclk  in  1  SPI clock, asynchronous to `clock`, mode 0.
- spi_ss  in  1  slave select, active low.
- spi_mosi  in  1  serial data in, MSB first.
- spi_miso  out  1  serial data out.
- spi_miso_oe  out  1  MISO output enable; high while spi_ss is low (synchronised).
- coef  out  BANKS*TAPS*COEF_W  active coefficients, flattened; bank b, tap t sits at bits [((b*TAPS+t)+1)*COEF_W-1 -: COEF_W].
- coef_update  out  1  one-cycle pulse when the active set changes.
- frame_err  out  1  one-cycle pulse per malformed frame.

## Operation
- **Frame format:** 32 bits, MSB first.
  - bit31: R/W (1 = write).
  - bits 30:24: address.
  - bits 23:0: data.
  - Word k (k = 0..3) occupies data[23-k*COEF_W -: COEF_W]; the remaining low bits are don't-care on write and read back as 0.
- **Address map:** addr = 1 + b*(TAPS/4) + q holds taps 4q..4q+3 of bank b. Valid range is 1 .. BANKS*TAPS/4. All other addresses, except ADDR_COMMIT and ADDR_STATUS, are unmapped.
- **Write:** after the 32nd bit, data is written to the shadow register of the addressed word. Shadow updates never affect `coef`.
- **Commit:** a write to ADDR_COMMIT with data[0] = 1 copies all shadow registers to active, then pulses coef_update. If data[0] = 0, the frame is a no-op.
- **Read:** after the 8th bit, the read word is latched into the MISO shift register.
  - Mapped address: the shadow word.
  - ADDR_STATUS: {err_cnt[7:0], 15'b0, busy}.
  - Anything else: 0.
  - MISO outputs 0 during bits 0..7, then the latched 24 bits MSB first.
- **Frame errors:** each error increments err_cnt (8-bit, saturating) and pulses frame_err. An error is any of:
  - spi_ss rising after 1 to 31 bits (aborted frame; no write occurs);
  - a write to an unmapped address or to ADDR_STATUS.
- **Over-long frames:** bits beyond 32 are ignored until spi_ss rises, with no error and no second write.
- **Framing reset:** the bit counter clears whenever spi_ss is high.
- **Reset values:** all shadow and active registers 0, coef = 0, err_cnt = 0, spi_miso = 0, spi_miso_oe = 0, coef_update = 0, frame_err = 0.
- **Reset mid-frame:** the frame is discarded; the next frame starts clean once spi_ss has been seen high.

## Timing
- **Synchronisation:** spi_sclk, spi_ss and spi_mosi each pass through a 2-flop synchroniser. SCLK edges are detected from the synchronised value, giving 3 cycles of latency from pin to edge strobe.
- **Sampling:** MOSI is sampled on the detected SCLK rising edge. MISO shifts on the detected falling edge.
- **Write / commit latency:**
  - Shadow write: 1 clock after the 32nd rising-edge strobe.
  - Commit: `coef` updates 1 clock after the 32nd strobe; coef_update is high in that same cycle.
- **Simultaneous events:**
  - A shadow write and a commit cannot land in the same cycle (one frame does one or the other).
  - A commit completing in the same cycle as reset is lost, because reset wins.
- **busy:** high from the commit strobe until coef_update has been issued (1 cycle).
- **frame_err:** pulses 1 clock after the synchronised spi_ss rise, or 1 clock after the 32nd strobe for a bad write.

## Structure
- Package spi_cfg_pkg holds:
  - frame field positions (RW_BIT, ADDR_MSB/LSB, DATA_MSB);
  - the ADDR_COMMIT and ADDR_STATUS defaults;
  - the frame length constant 32;
  - function addr_to_bank_quad(addr) returning {valid, bank, quad}.
- Sub-module spi_frame_rx owns:
  - the synchronisers and edge detection;
  - the bit counter and RX shift register;
  - the MISO shift register.
- spi_frame_rx outputs addr_valid (after bit 8), frame_done with {rw, addr, data}, and frame_abort.
- The top level holds the shadow/active arrays, the decode, err_cnt and the commit logic.

## Test plan
- **Reset:** assert reset for 2 cycles -> coef = 0, spi_miso_oe = 0, err_cnt reads 0 via ADDR_STATUS.
- **Write then commit:** write 0x83 with taps 1, 2, 3, 4 (bits 23:4 = 0x08864), then commit with 0xFE_000001 -> bank 1 taps 0..3 = 1, 2, 3, 4 only after the commit, and coef_update pulses exactly once.
- **Read-back:** read 0x03 after the write -> MISO returns 0x088640 in bits 23:0, with zeros during the first 8 bits.
- **Aborted frame:** raise spi_ss after 20 bits of a write to 0x01 -> shadow unchanged, one frame_err pulse, err_cnt = 1.
- **Unmapped write:** write to 0x40 -> no register changes, err_cnt increments; a read of 0x40 returns 0.
- **Over-long frame plus mid-frame reset:**
  - 40-bit frame -> exactly one write.
  - reset at bit 16 of the next frame -> nothing written, and the following frame decodes correctly.
